// File: rtl/npu_out_pkg.sv
// npu_out_pkg: shared definitions for the NPU output sequencer.
//   state_e  - sequencer state encoding (IDLE / LOAD / XFER)
//   STALL_W  - width of the optional write-stall counter
package npu_out_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_XFER = 2'd2
  } state_e;

  localparam int STALL_W = 16;

endpackage

// File: rtl/out_addr_ctr.sv
// out_addr_ctr: word counter and write-address register for one output burst.
//   clk, reset - system clock, synchronous active-high reset
//   load_i     - start of burst: addr <= base_i, cnt <= 0 (wins over inc_i)
//   inc_i      - one word accepted: cnt++, addr++ (addr wraps mod 2^ADDR_W)
//   base_i     - burst start address
//   addr_o     - current write address
//   last_o     - current word is the final word of the burst
module out_addr_ctr #(
  parameter int NUM_WORDS = 8,
  parameter int ADDR_W    = 8,
  parameter int CNT_W     = $clog2(NUM_WORDS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic              inc_i,
  input  logic [ADDR_W-1:0] base_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o
);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  always_comb begin
    cnt_d  = cnt_q;
    addr_d = addr_q;
    if (load_i) begin
      cnt_d  = '0;
      addr_d = base_i;
    end else if (inc_i) begin
      cnt_d  = cnt_q + CNT_W'(1);
      addr_d = addr_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      addr_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      addr_q <= addr_d;
    end
  end

  assign addr_o = addr_q;
  assign last_o = (cnt_q == CNT_W'(NUM_WORDS - 1));

endmodule

// File: rtl/fsm_out_seq.sv
// fsm_out_seq: NPU result-path output sequencer. On a ReLU start request it
// loads the output PISO, then shifts NUM_WORDS words to result memory through
// a valid/ready write port with an auto-incrementing address. One further
// start request can be queued while a burst is in flight.
//
// Ports:
//   clk, reset   - system clock, synchronous active-high reset
//   enable       - global advance; 0 freezes state, counters and pending flag
//   EN_ReLU      - start request pulse
//   base_addr    - burst start address, sampled at burst launch
//   wr_ready     - memory accepts the write this cycle
//   EN_PISO_OUT  - PISO clock enable (load in LOAD, shift on each accepted write)
//   SHIFT_OUT    - PISO mode: 0 = parallel load, 1 = shift
//   WR_EN        - write valid
//   wr_addr      - write address
//   OUT_DONE     - pulse on the final accepted write of a burst
//   busy         - sequencer not idle
//   stall_cnt    - (FSM_OUT_STALL_CNT_EN only) cycles with WR_EN=1 & wr_ready=0,
//                  saturating, cleared at each burst launch
//
// Build option: define FSM_OUT_STALL_CNT_EN to add the stall_cnt port.
//
// state | meaning
// IDLE  | waiting for EN_ReLU or a queued request
// LOAD  | one cycle, PISO parallel load
// XFER  | writing words, one per accepted handshake
module fsm_out_seq
  import npu_out_pkg::*;
#(
  parameter int NUM_WORDS = 8,
  parameter int ADDR_W    = 8,
  localparam int CNT_W    = $clog2(NUM_WORDS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              EN_ReLU,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              wr_ready,
  output logic              EN_PISO_OUT,
  output logic              SHIFT_OUT,
  output logic              WR_EN,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              OUT_DONE,
  output logic              busy
`ifdef FSM_OUT_STALL_CNT_EN
  ,
  output logic [STALL_W-1:0] stall_cnt
`endif
);

  state_e state_q, state_d;
  logic   pend_q, pend_d;
  logic   launch;
  logic   fire;
  logic   last_word;

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    launch      = 1'b0;
    fire        = 1'b0;
    EN_PISO_OUT = 1'b0;
    SHIFT_OUT   = 1'b1;
    WR_EN       = 1'b0;
    OUT_DONE    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enable && (EN_ReLU || pend_q)) begin
          state_d = ST_LOAD;
          launch  = 1'b1;
        end
      end
      ST_LOAD: begin
        SHIFT_OUT = 1'b0;
        if (enable) begin
          EN_PISO_OUT = 1'b1;
          state_d     = ST_XFER;
        end
      end
      ST_XFER: begin
        WR_EN       = enable;
        fire        = enable && wr_ready;
        EN_PISO_OUT = fire;
        if (fire && last_word) begin
          OUT_DONE = 1'b1;
          // Back-to-back launch skips IDLE entirely.
          if (pend_q || EN_ReLU) begin
            state_d = ST_LOAD;
            launch  = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A request consumed by this launch must not also be queued; a request
    // arriving while one is already queued is simply dropped.
    if (launch) begin
      pend_d = 1'b0;
    end else if (enable && EN_ReLU && (state_q != ST_IDLE)) begin
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

  out_addr_ctr #(
    .NUM_WORDS (NUM_WORDS),
    .ADDR_W    (ADDR_W),
    .CNT_W     (CNT_W)
  ) u_addr_ctr (
    .clk    (clk),
    .reset  (reset),
    .load_i (launch),
    .inc_i  (fire),
    .base_i (base_addr),
    .addr_o (wr_addr),
    .last_o (last_word)
  );

  assign busy = (state_q != ST_IDLE);

`ifdef FSM_OUT_STALL_CNT_EN
  logic [STALL_W-1:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (launch) begin
      stall_d = '0;
    end else if (WR_EN && !wr_ready && (stall_q != '1)) begin
      stall_d = stall_q + STALL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_fsm_out_seq.sv
module tb_fsm_out_seq;

  localparam int NW = 8;

  typedef struct {
    logic [7:0] addr;
    logic       last;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       EN_ReLU;
  logic [7:0] base_addr;
  logic       wr_ready;
  logic       EN_PISO_OUT;
  logic       SHIFT_OUT;
  logic       WR_EN;
  logic [7:0] wr_addr;
  logic       OUT_DONE;
  logic       busy;
`ifdef FSM_OUT_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   done_cyc = -1;
  int   done_cnt = 0;
  int   t0;
  int   done_before;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fsm_out_seq #(.NUM_WORDS(NW), .ADDR_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .EN_ReLU     (EN_ReLU),
    .base_addr   (base_addr),
    .wr_ready    (wr_ready),
    .EN_PISO_OUT (EN_PISO_OUT),
    .SHIFT_OUT   (SHIFT_OUT),
    .WR_EN       (WR_EN),
    .wr_addr     (wr_addr),
    .OUT_DONE    (OUT_DONE),
    .busy        (busy)
`ifdef FSM_OUT_STALL_CNT_EN
    ,
    .stall_cnt   (stall_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Drive a start request and queue the writes it should produce.
  task automatic start(input logic [7:0] base);
    EN_ReLU   = 1'b1;
    base_addr = base;
    for (int i = 0; i < NW; i++) begin
      exp_t e;
      e.addr = base + 8'(i);
      e.last = (i == NW - 1);
      sb.push_back(e);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_piso"},  EN_PISO_OUT, 0);
    chk({tag, "_shift"}, SHIFT_OUT, 1);
    chk({tag, "_wren"},  WR_EN, 0);
    chk({tag, "_done"},  OUT_DONE, 0);
    chk({tag, "_busy"},  busy, 0);
    chk({tag, "_addr"},  wr_addr, 0);
  endtask

  // Write-port monitor: every accepted write is matched against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (WR_EN) chk("piso_en_xfer", EN_PISO_OUT, wr_ready);
      if (WR_EN && wr_ready) begin
        chk("sb_nonempty", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("wr_addr", wr_addr, e.addr);
          chk("out_done", OUT_DONE, e.last);
        end
        if (OUT_DONE) begin
          done_cnt++;
          done_cyc = cyc;
        end
      end else begin
        chk("done_without_fire", OUT_DONE, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; enable = 1'b1; EN_ReLU = 1'b0; base_addr = 8'h00; wr_ready = 1'b1;
    tick(); tick();
    reset = 1'b0;
    sample();
    chk_reset_outputs("por");
`ifdef FSM_OUT_STALL_CNT_EN
    chk("por_stall", stall_cnt, 0);
`endif

    // Basic burst
    tick(); t0 = cyc; start(8'h40);
    tick(); EN_ReLU = 1'b0;
    sample();
    chk("b_load_piso", EN_PISO_OUT, 1);
    chk("b_load_shift", SHIFT_OUT, 0);
    chk("b_load_wren", WR_EN, 0);
    chk("b_load_busy", busy, 1);
    tick(); sample();
    chk("b_first_wren", WR_EN, 1);
    repeat (8) tick();
    sample();
    chk("b_busy_end", busy, 0);
    chk("b_done_cyc", done_cyc, t0 + 9);

    // Backpressure: stall 3 cycles at the third word
    tick(); t0 = cyc; start(8'h40);
    tick(); EN_ReLU = 1'b0;
    tick(); tick();
    for (int i = 0; i < 3; i++) begin
      tick(); wr_ready = 1'b0;
      sample();
      chk("bp_addr_hold", wr_addr, 8'h42);
      chk("bp_piso_off", EN_PISO_OUT, 0);
      chk("bp_wren", WR_EN, 1);
    end
    tick(); wr_ready = 1'b1;
    repeat (6) tick();
    sample();
    chk("bp_busy_end", busy, 0);
    chk("bp_done_cyc", done_cyc, t0 + 12);
`ifdef FSM_OUT_STALL_CNT_EN
    chk("bp_stall_cnt", stall_cnt, 3);
`endif

    // Queued start, third request dropped
    tick(); t0 = cyc; start(8'h40);
    tick(); EN_ReLU = 1'b0;
    sample();
`ifdef FSM_OUT_STALL_CNT_EN
    chk("q_stall_clr", stall_cnt, 0);
`endif
    tick(); tick(); tick();
    tick(); start(8'h80);
    tick(); EN_ReLU = 1'b1;
    tick(); EN_ReLU = 1'b0;
    tick();
    tick(); sample();
    chk("q_t9_busy", busy, 1);
    chk("q_t9_done", OUT_DONE, 1);
    tick(); sample();
    chk("q_load_piso", EN_PISO_OUT, 1);
    chk("q_load_shift", SHIFT_OUT, 0);
    chk("q_load_busy", busy, 1);
    repeat (9) tick();
    sample();
    chk("q_busy_end", busy, 0);
    chk("q_done_cyc", done_cyc, t0 + 18);
    tick(); tick(); sample();
    chk("q_drop_idle", busy, 0);

    // Enable freeze mid-XFER, EN_ReLU while frozen ignored
    tick(); t0 = cyc; start(8'h10);
    tick(); EN_ReLU = 1'b0;
    tick(); tick(); tick();
    tick(); enable = 1'b0;
    sample();
    chk("fz_wren", WR_EN, 0);
    chk("fz_addr", wr_addr, 8'h13);
    chk("fz_piso", EN_PISO_OUT, 0);
    chk("fz_busy", busy, 1);
    chk("fz_shift", SHIFT_OUT, 1);
    tick(); EN_ReLU = 1'b1;
    sample();
    chk("fz_addr2", wr_addr, 8'h13);
    tick(); enable = 1'b1; EN_ReLU = 1'b0;
    repeat (5) tick();
    sample();
    chk("fz_busy_end", busy, 0);
    chk("fz_done_cyc", done_cyc, t0 + 11);
    tick(); sample();
    chk("fz_no_pending", busy, 0);

    // Reset at the 5th write with a request queued
    done_before = done_cnt;
    tick(); t0 = cyc; start(8'h20);
    tick(); EN_ReLU = 1'b0;
    tick();
    tick(); EN_ReLU = 1'b1; base_addr = 8'h30;
    tick(); EN_ReLU = 1'b0;
    tick();
    tick(); reset = 1'b1;
    tick(); reset = 1'b0;
    chk("rst_sb_left", sb.size(), 4);
    sb.delete();
    sample();
    chk_reset_outputs("rst");
    repeat (4) tick();
    sample();
    chk("rst_pending_gone", busy, 0);
    chk("rst_no_done", done_cnt, done_before);

    // Address wrap
    tick(); t0 = cyc; start(8'hFD);
    tick(); EN_ReLU = 1'b0;
    repeat (9) tick();
    sample();
    chk("wrap_busy_end", busy, 0);
    chk("wrap_done_cyc", done_cyc, t0 + 9);

    tick(); tick();
    chk("sb_final", sb.size(), 0);
    chk("done_total", done_cnt, 6);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
